// File: rtl/clamp_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : clamp_sequencer
// Brief   : Clamp station sequencer: debounced arming, ready handshake with
//           timeout/retry, internally timed line/gear clamp, latched fault.
// Revision: 1.0 - initial release
// ============================================================================
module clamp_sequencer #(
   parameter int CNT_W         = 16,
   parameter int DEBOUNCE      = 4,
   parameter int READY_TIMEOUT = 1000,
   parameter int LINE_CYCLES   = 200,
   parameter int GEAR_CYCLES   = 500,
   parameter int MAX_RETRY     = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       flag,
   input  logic       detect,
   input  logic       ready,
   input  logic       mode,
   input  logic       abort,
   input  logic       clear_fault,
   output logic       open,
   output logic       en_sensor,
   output logic       en_acc,
   output logic       en_clamp,
   output logic       line_active,
   output logic       gear_active,
   output logic       busy,
   output logic       done,
   output logic       fault,
   output logic [1:0] fault_code,
   output logic [7:0] retry_cnt
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_ARM      = 3'd1,
      S_WAIT_RDY = 3'd2,
      S_LINE     = 3'd3,
      S_GEAR     = 3'd4,
      S_RELEASE  = 3'd5,
      S_FAULT    = 3'd6
   } state_t;

   localparam logic [CNT_W-1:0] C_DEB_LAST  = CNT_W'(DEBOUNCE - 1);
   localparam logic [CNT_W-1:0] C_TO_LAST   = CNT_W'(READY_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] C_LINE_LAST = CNT_W'(LINE_CYCLES - 1);
   localparam logic [CNT_W-1:0] C_GEAR_LAST = CNT_W'(GEAR_CYCLES - 1);
   localparam logic [7:0]       C_MAX_RETRY = 8'(MAX_RETRY);
   localparam logic [1:0]       C_CODE_NONE    = 2'b00;
   localparam logic [1:0]       C_CODE_TIMEOUT = 2'b01;
   localparam logic [1:0]       C_CODE_ABORT   = 2'b10;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             mode_q, mode_d;
   logic [7:0]       retry_q, retry_d;
   logic [1:0]       code_q, code_d;

   logic             w_armed;
   logic [7:0]       w_retry_inc;

   assign w_armed     = flag & detect;
   assign w_retry_inc = retry_q + 8'd1;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CNT_W'(1);
      mode_d  = mode_q;
      retry_d = retry_q;
      code_d  = code_q;
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (w_armed) state_d = S_ARM;
         end
         S_ARM: begin
            if (!w_armed) begin
               state_d = S_IDLE;
            end else if (cnt_q == C_DEB_LAST) begin
               state_d = S_WAIT_RDY;
               mode_d  = mode;
            end
         end
         S_WAIT_RDY: begin
            if (ready) begin
               state_d = mode_q ? S_GEAR : S_LINE;
            end else if (cnt_q == C_TO_LAST) begin
               retry_d = w_retry_inc;
               if (w_retry_inc == C_MAX_RETRY) begin
                  state_d = S_FAULT;
                  code_d  = C_CODE_TIMEOUT;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         S_LINE: begin
            if (abort) begin
               state_d = S_FAULT;
               code_d  = C_CODE_ABORT;
            end else if (cnt_q == C_LINE_LAST) begin
               state_d = S_RELEASE;
            end
         end
         S_GEAR: begin
            if (abort) begin
               state_d = S_FAULT;
               code_d  = C_CODE_ABORT;
            end else if (cnt_q == C_GEAR_LAST) begin
               state_d = S_RELEASE;
            end
         end
         S_RELEASE: begin
            retry_d = 8'd0;
            state_d = S_IDLE;
         end
         S_FAULT: begin
            cnt_d = '0;
            if (clear_fault && !flag) begin
               state_d = S_IDLE;
               code_d  = C_CODE_NONE;
               retry_d = 8'd0;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // Every transition restarts the phase counter.
      if (state_d != state_q) cnt_d = '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         mode_q  <= 1'b0;
         retry_q <= 8'd0;
         code_q  <= C_CODE_NONE;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
         retry_q <= retry_d;
         code_q  <= code_d;
      end
   end

   assign open        = (state_q != S_LINE);
   assign en_sensor   = (state_q == S_IDLE) || (state_q == S_ARM) || (state_q == S_WAIT_RDY);
   assign en_acc      = (state_q == S_WAIT_RDY);
   assign en_clamp    = (state_q == S_LINE) || (state_q == S_GEAR);
   assign line_active = (state_q == S_LINE);
   assign gear_active = (state_q == S_GEAR);
   assign busy        = (state_q != S_IDLE) && (state_q != S_FAULT);
   assign done        = (state_q == S_RELEASE);
   assign fault       = (state_q == S_FAULT);
   assign fault_code  = code_q;
   assign retry_cnt   = retry_q;

endmodule
`default_nettype wire

// File: tb/tb_clamp_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_clamp_sequencer
// Brief   : Directed self-checking bench for clamp_sequencer (default params).
// Revision: 1.0 - initial release
// ============================================================================
module tb_clamp_sequencer;

   logic       clk = 1'b0;
   logic       reset, flag, detect, ready, mode, abort, clear_fault;
   logic       open, en_sensor, en_acc, en_clamp, line_active, gear_active;
   logic       busy, done, fault;
   logic [1:0] fault_code;
   logic [7:0] retry_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   // Output vector order: open,en_sensor,en_acc,en_clamp,line,gear,busy,done,fault
   localparam logic [8:0] O_IDLE    = 9'b110000000;
   localparam logic [8:0] O_ARM     = 9'b110000100;
   localparam logic [8:0] O_WAIT    = 9'b111000100;
   localparam logic [8:0] O_LINE    = 9'b000110100;
   localparam logic [8:0] O_GEAR    = 9'b100101100;
   localparam logic [8:0] O_RELEASE = 9'b100000110;
   localparam logic [8:0] O_FAULT   = 9'b100000001;

   clamp_sequencer dut (
      .clk(clk), .reset(reset), .flag(flag), .detect(detect), .ready(ready),
      .mode(mode), .abort(abort), .clear_fault(clear_fault),
      .open(open), .en_sensor(en_sensor), .en_acc(en_acc), .en_clamp(en_clamp),
      .line_active(line_active), .gear_active(gear_active), .busy(busy),
      .done(done), .fault(fault), .fault_code(fault_code), .retry_cnt(retry_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [8:0] outs();
      return {open, en_sensor, en_acc, en_clamp, line_active, gear_active, busy, done, fault};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // From IDLE with flag&detect high: 1 cycle to ARM, 4 debounce cycles, then WAIT_RDY.
   task automatic run_to_wait(input string tag);
      for (int i = 0; i < 5; i++) tick();
      chk(tag, outs(), O_WAIT);
   endtask

   initial begin
      reset = 1'b1; flag = 1'b1; detect = 1'b1; ready = 1'b0;
      mode = 1'b0; abort = 1'b0; clear_fault = 1'b0;

      // Reset with flag&detect high
      tick(); tick();
      chk("reset_outs", outs(), O_IDLE);
      chk("reset_retry", retry_cnt, 8'd0);
      chk("reset_code", fault_code, 2'b00);
      reset = 1'b0;
      tick();
      chk("arm_after_reset", outs(), O_ARM);

      // Debounce: 3 cycles high then low, never reaches WAIT_RDY
      detect = 1'b0;
      tick();
      chk("back_idle", outs(), O_IDLE);
      detect = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("deb_short_arm", outs(), O_ARM);
      end
      detect = 1'b0;
      tick();
      chk("deb_short_idle", outs(), O_IDLE);

      // Debounce: held high -> en_acc on the 5th cycle
      detect = 1'b1; mode = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("deb_long_arm", outs(), O_ARM);
      end
      tick();
      chk("deb_long_wait", outs(), O_WAIT);

      // Line cycle: 200 clamp cycles then one done pulse
      ready = 1'b1;
      tick();
      ready = 1'b0; flag = 1'b0; detect = 1'b0; mode = 1'b1;
      for (int i = 0; i < 200; i++) begin
         chk("line_phase", outs(), O_LINE);
         tick();
      end
      chk("line_release", outs(), O_RELEASE);
      tick();
      chk("line_idle", outs(), O_IDLE);

      // Gear cycle with mode toggles after latching
      flag = 1'b1; detect = 1'b1; mode = 1'b1;
      run_to_wait("gear_wait");
      mode = 1'b0; ready = 1'b1;
      tick();
      ready = 1'b0; flag = 1'b0; detect = 1'b0;
      for (int i = 0; i < 500; i++) begin
         if (i == 250) mode = 1'b1;
         if (i == 251) mode = 1'b0;
         chk("gear_phase", outs(), O_GEAR);
         tick();
      end
      chk("gear_release", outs(), O_RELEASE);
      tick();
      chk("gear_idle", outs(), O_IDLE);

      // Timeout/retry into FAULT
      flag = 1'b1; detect = 1'b1; mode = 1'b0;
      for (int r = 1; r <= 3; r++) begin
         run_to_wait("to_wait");
         for (int i = 0; i < 1000; i++) begin
            chk("to_waiting", outs(), O_WAIT);
            tick();
         end
         chk("to_retry", retry_cnt, r);
         chk("to_state", outs(), (r == 3) ? O_FAULT : O_IDLE);
      end
      chk("to_code", fault_code, 2'b01);
      clear_fault = 1'b1;
      tick();
      chk("clr_flag_hi_state", outs(), O_FAULT);
      chk("clr_flag_hi_code", fault_code, 2'b01);
      flag = 1'b0;
      tick();
      clear_fault = 1'b0; detect = 1'b0;
      chk("clr_state", outs(), O_IDLE);
      chk("clr_retry", retry_cnt, 8'd0);
      chk("clr_code", fault_code, 2'b00);

      // Abort ignored in WAIT_RDY, wins on final LINE cycle
      flag = 1'b1; detect = 1'b1;
      run_to_wait("ab_wait");
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("ab_ignored_wait", outs(), O_WAIT);
      ready = 1'b1;
      tick();
      ready = 1'b0; flag = 1'b0; detect = 1'b0;
      for (int i = 0; i < 199; i++) begin
         chk("ab_line", outs(), O_LINE);
         tick();
      end
      chk("ab_last_line", outs(), O_LINE);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("ab_fault", outs(), O_FAULT);
      chk("ab_code", fault_code, 2'b10);
      tick();
      chk("ab_fault_hold", outs(), O_FAULT);
      clear_fault = 1'b1;
      tick();
      clear_fault = 1'b0;
      chk("ab_clear", outs(), O_IDLE);
      chk("ab_clear_code", fault_code, 2'b00);

      // Mid-clamp reset releases the clamp
      flag = 1'b1; detect = 1'b1;
      run_to_wait("rst_wait");
      ready = 1'b1;
      tick();
      ready = 1'b0; flag = 1'b0; detect = 1'b0;
      chk("rst_line", outs(), O_LINE);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rst_idle", outs(), O_IDLE);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/clamp_sequencer.md
Name: clamp_sequencer

Overview:
- Parametrised successor to the single-shot cable clamp controller.
- Sequences one clamp station: debounced detect arming, ready handshake with timeout and retry, line or gear clamp phases timed internally, a release/done pulse, and a latched fault state.
- Sits between the cable sensor/accumulator front end and the clamp actuator drivers.
- Replaces the external line/gear timers with internal counters.

Parameters:
- CNT_W, 16: width of the shared phase counter; every cycle-count parameter below must be ≤ 2^CNT_W−1.
- DEBOUNCE, 4: consecutive cycles flag&detect must hold before arming (≥1).
- READY_TIMEOUT, 1000: cycles allowed in WAIT_RDY for ready (≥1).
- LINE_CYCLES, 200: clamp duration in LINE (≥1).
- GEAR_CYCLES, 500: clamp duration in GEAR (≥1).
- MAX_RETRY, 3: consecutive ready timeouts that cause a fault (1..255).

Ports:
- clk, in, 1: sole clock, rising edge.
- reset, in, 1: synchronous, active-high reset.
- flag, in, 1: station enable from the upstream controller.
- detect, in, 1: cable-present sensor.
- ready, in, 1: accumulator ready.
- mode, in, 1: 0 = line clamp, 1 = gear clamp; sampled on entry to WAIT_RDY.
- abort, in, 1: emergency stop.
- clear_fault, in, 1: fault acknowledge.
- open, out, 1: gate open.
- en_sensor, out, 1: sensor enable.
- en_acc, out, 1: accumulator enable.
- en_clamp, out, 1: clamp actuator enable.
- line_active, out, 1: LINE phase in progress.
- gear_active, out, 1: GEAR phase in progress.
- busy, out, 1: state ≠ IDLE and ≠ FAULT.
- done, out, 1: one-cycle pulse, cycle completed.
- fault, out, 1: FAULT state.
- fault_code, out, 2: 00 none, 01 ready timeout, 10 abort; holds its value while in FAULT.
- retry_cnt, out, 8: current consecutive-timeout count.

Behaviour:
- One synchronous always block holds the state register, the phase counter cnt (CNT_W bits), the latched mode, retry_cnt and fault_code. reset is evaluated before all else.
- Reset values: state = IDLE, cnt = 0, retry_cnt = 0, fault_code = 00.
- Outputs are decoded combinationally from the registered state (Moore). Reset output values are therefore open = 1, en_sensor = 1, all other outputs 0.
- Every state transition clears cnt to 0. Within a state, cnt increments by 1 per cycle and never wraps, since the exit compare fires first.
- IDLE: open = 1, en_sensor = 1.
  - If flag&detect → ARM.
- ARM: open = 1, en_sensor = 1.
  - If !(flag&detect) → IDLE.
  - Else if cnt == DEBOUNCE−1 → WAIT_RDY and latch mode.
  - Else cnt++.
  - flag&detect continuously high from cycle t reaches WAIT_RDY at t+DEBOUNCE+1.
- WAIT_RDY: open = 1, en_sensor = 1, en_acc = 1.
  - If ready → LINE (latched mode = 0) or GEAR (latched mode = 1).
  - Else if cnt == READY_TIMEOUT−1: retry_cnt++. If the new value == MAX_RETRY → FAULT with fault_code = 01; else → IDLE.
  - ready and timeout in the same cycle: ready wins, no retry increment.
  - flag is ignored from WAIT_RDY onward.
- LINE: open = 0, en_clamp = 1, line_active = 1.
  - abort → FAULT, fault_code = 10.
  - Else if cnt == LINE_CYCLES−1 → RELEASE.
- GEAR: open = 1, en_clamp = 1, gear_active = 1.
  - abort → FAULT, fault_code = 10.
  - Else if cnt == GEAR_CYCLES−1 → RELEASE.
- abort and phase expiry in the same cycle: abort wins.
- abort in IDLE, ARM, WAIT_RDY or RELEASE is ignored.
- RELEASE: exactly one cycle. open = 1, en_clamp = 0, done = 1. retry_cnt cleared to 0 → IDLE.
- FAULT: open = 1, all enables 0, fault = 1, busy = 0.
  - Exit to IDLE only when clear_fault = 1 and flag = 0. On that exit, fault_code and retry_cnt clear to 0.
  - clear_fault while flag = 1 is ignored.
- A mid-operation reset returns to IDLE in the next cycle with clamp released (en_clamp = 0, open = 1).
- The latched mode holds for the whole clamp phase; mode changes during WAIT_RDY, LINE or GEAR have no effect until the next arming.
- Unreachable state encodings → IDLE.

Test Plan:
- Reset/idle: assert reset for 2 cycles while flag = detect = 1 → open = 1, en_sensor = 1, all else 0; ARM is entered on the first cycle after reset deasserts.
- Debounce (DEBOUNCE = 4): detect high for 3 cycles, then low → back to IDLE, en_acc never 1. Then detect high for 5 cycles → en_acc = 1 starting at cycle 5.
- Line cycle (mode = 0, LINE_CYCLES = 200): ready raised in WAIT_RDY → en_clamp = 1, open = 0 for exactly 200 cycles, then done = 1 for 1 cycle, then IDLE.
- Gear cycle with mode toggled mid-clamp (mode = 1, GEAR_CYCLES = 500): clamp stays 500 cycles with gear_active = 1, open = 1; mode toggle has no effect; done pulses once.
- Timeout/retry (READY_TIMEOUT = 1000, MAX_RETRY = 3): ready never asserted → retry_cnt goes 1, 2, then FAULT with fault_code = 01. clear_fault with flag = 1 is ignored; with flag = 0 → IDLE, retry_cnt = 0.
- Abort priority: abort on the final LINE cycle (cnt = 199) → FAULT with fault_code = 10, no done pulse, en_clamp = 0 on the next cycle.
